// File: rtl/pmodclp_bus_sequencer.sv
// Purpose: round-robin arbiter for two byte requesters plus HD44780 write timing (setup, E pulse, hold, exec wait) for the PmodCLP LCD.
// Latency: byte captured on the ready edge; E rises T_SETUP_CYC+1 cycles after the handshake cycle; next accept T_SETUP+T_EPW+T_HOLD+T_wait+1 cycles later.
// Backpressure: reqN_ready is raised only in IDLE and only for the arbitration winner; macro LCD_INIT_EN adds power-up wait and init sequence.
module pmodclp_bus_sequencer #(
  parameter int T_SETUP_CYC   = 4,
  parameter int T_EPW_CYC     = 25,
  parameter int T_HOLD_CYC    = 2,
  parameter int T_EXEC_CYC    = 4000,
  parameter int T_CLEAR_CYC   = 164000,
  parameter int T_POWERUP_CYC = 2000000
) (
  input  logic       sysclk,
  input  logic       sysreset_n,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       grant_id,
  output logic       busy,
  output logic [7:0] lcd_d,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EPW, S_HOLD, S_EXEC, S_PWRUP
  } state_t;

  // Every timing value must fit the 21-bit down-counter; a misconfigured
  // instance parks in IDLE instead of strobing the LCD with wrong timing.
  localparam int CNT_LIM = 1 << 21;
  localparam bit PARAMS_OK =
    (T_SETUP_CYC   >= 1) && (T_SETUP_CYC   < CNT_LIM) &&
    (T_EPW_CYC     >= 1) && (T_EPW_CYC     < CNT_LIM) &&
    (T_HOLD_CYC    >= 1) && (T_HOLD_CYC    < CNT_LIM) &&
    (T_EXEC_CYC    >= 1) && (T_EXEC_CYC    < CNT_LIM) &&
    (T_CLEAR_CYC   >= 1) && (T_CLEAR_CYC   < CNT_LIM) &&
    (T_POWERUP_CYC >= 1) && (T_POWERUP_CYC < CNT_LIM);

  localparam logic [20:0] LD_SETUP = 21'(T_SETUP_CYC - 1);
  localparam logic [20:0] LD_EPW   = 21'(T_EPW_CYC - 1);
  localparam logic [20:0] LD_HOLD  = 21'(T_HOLD_CYC - 1);
  localparam logic [20:0] LD_EXEC  = 21'(T_EXEC_CYC - 1);
  localparam logic [20:0] LD_CLEAR = 21'(T_CLEAR_CYC - 1);

`ifdef LCD_INIT_EN
  localparam state_t      RST_STATE = S_PWRUP;
  localparam logic [20:0] RST_CNT   = 21'(T_POWERUP_CYC - 1);
  localparam logic        RST_BUSY  = 1'b1;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  logic [1:0] init_idx, init_idx_nx;
  logic       init_act, init_act_nx;
`else
  localparam state_t      RST_STATE = S_IDLE;
  localparam logic [20:0] RST_CNT   = 21'd0;
  localparam logic        RST_BUSY  = 1'b0;
`endif

  state_t      state, state_nx;
  logic [20:0] cnt, cnt_nx;
  logic        last_grant;
  logic        take, take_id;
  logic        load, load_rs;
  logic [7:0]  load_d;
  logic        is_clear;

  // Clear (0x01) and return-home (0x02/0x03) instructions need the long wait.
  assign is_clear = !lcd_rs && (lcd_d[7:2] == 6'd0) && (lcd_d[1:0] != 2'd0);
  assign lcd_rw   = 1'b0;

  // Next-state, counter reload, arbitration and ready decode.
  always_comb begin
    state_nx   = state;
    cnt_nx     = (cnt != 21'd0) ? cnt - 21'd1 : cnt;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    take_id    = 1'b0;
    load       = 1'b0;
    load_d     = lcd_d;
    load_rs    = lcd_rs;
`ifdef LCD_INIT_EN
    init_idx_nx = init_idx;
    init_act_nx = init_act;
`endif
    case (state)
      S_IDLE: begin
        // last_grant=1 means requester 1 was served last, so requester 0 wins a tie.
        if (PARAMS_OK && req0_valid && (!req1_valid || last_grant)) begin
          req0_ready = 1'b1;
          take       = 1'b1;
          take_id    = 1'b0;
          load_d     = req0_data;
          load_rs    = req0_rs;
        end else if (PARAMS_OK && req1_valid) begin
          req1_ready = 1'b1;
          take       = 1'b1;
          take_id    = 1'b1;
          load_d     = req1_data;
          load_rs    = req1_rs;
        end
        if (take) begin
          load     = 1'b1;
          state_nx = S_SETUP;
          cnt_nx   = LD_SETUP;
        end
      end
      S_SETUP: if (cnt == 21'd0) begin
        state_nx = S_EPW;
        cnt_nx   = LD_EPW;
      end
      S_EPW: if (cnt == 21'd0) begin
        state_nx = S_HOLD;
        cnt_nx   = LD_HOLD;
      end
      S_HOLD: if (cnt == 21'd0) begin
        state_nx = S_EXEC;
        cnt_nx   = is_clear ? LD_CLEAR : LD_EXEC;
      end
      S_EXEC: if (cnt == 21'd0) begin
`ifdef LCD_INIT_EN
        if (init_act && (init_idx != 2'd3)) begin
          init_idx_nx = init_idx + 2'd1;
          state_nx    = S_SETUP;
          cnt_nx      = LD_SETUP;
          load        = 1'b1;
          load_d      = init_byte(init_idx + 2'd1);
          load_rs     = 1'b0;
        end else begin
          state_nx    = S_IDLE;
          init_act_nx = 1'b0;
        end
`else
        state_nx = S_IDLE;
`endif
      end
`ifdef LCD_INIT_EN
      S_PWRUP: if (cnt == 21'd0) begin
        state_nx    = S_SETUP;
        cnt_nx      = LD_SETUP;
        load        = 1'b1;
        load_d      = init_byte(2'd0);
        load_rs     = 1'b0;
        init_act_nx = 1'b1;
        init_idx_nx = 2'd0;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // State, counter and round-robin pointer registers.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state      <= RST_STATE;
      cnt        <= RST_CNT;
      last_grant <= 1'b1;
`ifdef LCD_INIT_EN
      init_idx   <= 2'd0;
      init_act   <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      if (take) last_grant <= take_id;
`ifdef LCD_INIT_EN
      init_idx   <= init_idx_nx;
      init_act   <= init_act_nx;
`endif
    end
  end

  // Registered bus outputs follow the next state so they change on the same edge as the state.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      lcd_d    <= 8'd0;
      lcd_rs   <= 1'b0;
      lcd_e    <= 1'b0;
      grant_id <= 1'b0;
      busy     <= RST_BUSY;
    end else begin
      lcd_e <= (state_nx == S_EPW);
      busy  <= (state_nx != S_IDLE);
      if (load) begin
        lcd_d  <= load_d;
        lcd_rs <= load_rs;
      end
      if (take) grant_id <= take_id;
    end
  end

endmodule

// File: tb/tb_pmodclp_bus_sequencer.sv
// Purpose: self-checking bench for pmodclp_bus_sequencer with short timing overrides.
// Latency: inputs driven 1 time unit after posedge, outputs sampled after the edge; every wait is bounded.
// Backpressure: requesters hold valid until ready and drop it right after the handshake edge.
module tb_pmodclp_bus_sequencer;
  localparam int TS = 2, TE = 3, TH = 1, TX = 10, TC = 50, TP = 20;
`ifdef LCD_INIT_EN
  localparam logic RST_BUSY_EXP = 1'b1;
`else
  localparam logic RST_BUSY_EXP = 1'b0;
`endif

  logic       sysclk, sysreset_n;
  logic       req0_valid, req0_rs, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_rs, req1_ready;
  logic [7:0] req1_data;
  logic       grant_id, busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_d;

  pmodclp_bus_sequencer #(
    .T_SETUP_CYC(TS), .T_EPW_CYC(TE), .T_HOLD_CYC(TH),
    .T_EXEC_CYC(TX), .T_CLEAR_CYC(TC), .T_POWERUP_CYC(TP)
  ) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
    .grant_id(grant_id), .busy(busy), .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: records every E strobe and counts protocol violations.
  typedef struct packed { logic rs; logic [7:0] d; logic gid; } strobe_t;
  strobe_t strobe_q[$];
  logic e_prev = 1'b0;
  int viol_both = 0, viol_rw = 0, viol_rdy_busy = 0;

  always @(negedge sysclk) begin
    if (lcd_e && !e_prev) strobe_q.push_back({lcd_rs, lcd_d, grant_id});
    e_prev = lcd_e;
    if (req0_ready && req1_ready) viol_both++;
    if (lcd_rw !== 1'b0) viol_rw++;
    if ((req0_ready || req1_ready) && busy) viol_rdy_busy++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic v0; logic rs0; logic [7:0] d0;
    logic v1; logic rs1; logic [7:0] d1;
    logic gid; logic [7:0] ed; logic ers; int ebusy;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic rs0, input logic [7:0] d0,
                              input logic v1, input logic rs1, input logic [7:0] d1,
                              input logic gid, input logic [7:0] ed, input logic ers, input int ebusy);
    vec_t v;
    v.v0 = v0; v.rs0 = rs0; v.d0 = d0; v.v1 = v1; v.rs1 = rs1; v.d1 = d1;
    v.gid = gid; v.ed = ed; v.ers = ers; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic cyc();
    @(posedge sysclk); #1;
  endtask

  // Returns at the cycle after the handshake edge (k=1); id=-1 on timeout.
  task automatic wait_hs(output int id, input int bound);
    id = -1;
    for (int i = 0; i < bound; i++) begin
      #1;
      if (req0_ready) id = 0;
      else if (req1_ready) id = 1;
      @(posedge sysclk); #1;
      if (id >= 0) break;
    end
    check("handshake seen", (id >= 0), 1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin cyc(); n++; end
    check("wait idle", busy, 0);
  endtask

  // Walks one transfer from k=1 until the first IDLE cycle.
  task automatic observe(input logic [7:0] ed, input logic ers,
                         output int t_rise, output int e_hi, output int busy_n, output int stable);
    t_rise = 0; e_hi = 0; busy_n = 0; stable = 1;
    for (int k = 1; k < 400; k++) begin
      if (!busy) break;
      busy_n++;
      if (lcd_e) begin
        e_hi++;
        if (t_rise == 0) t_rise = k;
      end
      if (t_rise == 0 && (lcd_d !== ed || lcd_rs !== ers)) stable = 0;
      cyc();
    end
  endtask

  task automatic pop_strobe(input string name, input logic [7:0] d, input logic rs, input logic gid);
    strobe_t s;
    if (strobe_q.size() == 0) begin
      check({name, " strobe present"}, 0, 1);
    end else begin
      s = strobe_q.pop_front();
      check({name, " strobe"}, {23'd0, s}, {23'd0, rs, d, gid});
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int id, t_rise, e_hi, busy_n, stable;
    req0_valid = v.v0; req0_rs = v.rs0; req0_data = v.d0;
    req1_valid = v.v1; req1_rs = v.rs1; req1_data = v.d1;
    wait_hs(id, 8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check({tag, " ready id"}, id, {31'd0, v.gid});
    check({tag, " grant_id"}, grant_id, v.gid);
    observe(v.ed, v.ers, t_rise, e_hi, busy_n, stable);
    check({tag, " E rise cycle"}, t_rise, TS + 1);
    check({tag, " E width"}, e_hi, TE);
    check({tag, " busy cycles"}, busy_n, v.ebusy);
    check({tag, " setup stable"}, stable, 1);
    check({tag, " data held"}, {23'd0, lcd_rs, lcd_d}, {23'd0, v.ers, v.ed});
    pop_strobe(tag, v.ed, v.ers, v.gid);
  endtask

  vec_t tbl[9];
  int id, hs, k, bad, model_last, w;
  logic quiet, clr;
  vec_t rv;

  initial begin
    // Requester 0 wins the first tie; pointer then alternates on ties only.
    tbl[0] = mk(1, 1, 8'h41, 0, 0, 8'h00, 0, 8'h41, 1, TS+TE+TH+TX);
    tbl[1] = mk(0, 0, 8'h00, 1, 0, 8'h01, 1, 8'h01, 0, TS+TE+TH+TC);
    tbl[2] = mk(1, 1, 8'h30, 1, 1, 8'h31, 0, 8'h30, 1, TS+TE+TH+TX);
    tbl[3] = mk(1, 0, 8'h02, 1, 0, 8'h03, 1, 8'h03, 0, TS+TE+TH+TC);
    tbl[4] = mk(1, 0, 8'h04, 0, 0, 8'h00, 0, 8'h04, 0, TS+TE+TH+TX);
    tbl[5] = mk(0, 0, 8'h00, 1, 1, 8'h02, 1, 8'h02, 1, TS+TE+TH+TX);
    tbl[6] = mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, TS+TE+TH+TX);
    tbl[7] = mk(1, 0, 8'h03, 1, 1, 8'hFF, 1, 8'hFF, 1, TS+TE+TH+TX);
    tbl[8] = mk(1, 0, 8'h01, 1, 1, 8'h22, 0, 8'h01, 0, TS+TE+TH+TC);

    sysreset_n = 1'b0;
    req0_valid = 1'b0; req0_rs = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_rs = 1'b0; req1_data = 8'h00;
    #12;
    check("reset lcd_e", lcd_e, 0);
    check("reset lcd_d", lcd_d, 0);
    check("reset lcd_rs", lcd_rs, 0);
    check("reset grant_id", grant_id, 0);
    check("reset busy", busy, RST_BUSY_EXP);
    check("reset ready", {req0_ready, req1_ready}, 0);
    @(posedge sysclk); #1;
    sysreset_n = 1'b1;

`ifdef LCD_INIT_EN
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h41;
    k = 0; bad = 0; hs = 0;
    while (busy && k < 1000) begin
      cyc(); k++;
      if (lcd_e && hs == 0) hs = k;
      #1; if (req0_ready && busy) bad++;
    end
    check("init ready held", bad, 0);
    check("init first E cycle", hs, TP + TS);
    #1; check("init ready after busy", req0_ready, 1);
    req0_valid = 1'b0;
    pop_strobe("init 0x38", 8'h38, 0, 0);
    pop_strobe("init 0x0C", 8'h0C, 0, 0);
    pop_strobe("init 0x01", 8'h01, 0, 0);
    pop_strobe("init 0x06", 8'h06, 0, 0);
    cyc();
`endif

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back clears from one requester: served every period, next accept at cycle 57.
    strobe_q.delete();
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h01;
    wait_hs(id, 8);
    check("b2b first id", id, 1);
    k = 1;
    while (k < 200) begin
      #1; if (req1_ready) break;
      @(posedge sysclk); #1; k++;
    end
    check("b2b next accept cycle", k, TS + TE + TH + TC + 1);
    @(posedge sysclk); #1;
    req1_valid = 1'b0;
    wait_idle(200);
    pop_strobe("b2b 1", 8'h01, 0, 1);
    pop_strobe("b2b 2", 8'h01, 0, 1);

    // Continuous contention alternates 0xAA / 0x55.
    strobe_q.delete();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h55;
    hs = 0;
    for (int c = 0; c < 400 && hs < 4; c++) begin
      #1; if (req0_ready || req1_ready) hs++;
      @(posedge sysclk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contention handshakes", hs, 4);
    wait_idle(200);
    pop_strobe("contention 0", 8'hAA, 1, 0);
    pop_strobe("contention 1", 8'h55, 1, 1);
    pop_strobe("contention 2", 8'hAA, 1, 0);
    pop_strobe("contention 3", 8'h55, 1, 1);

    // Hold-off: requester 1 rises during EPW and is taken on the first IDLE cycle.
    strobe_q.delete();
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h12;
    wait_hs(id, 8);
    req0_valid = 1'b0;
    check("holdoff first id", id, 0);
    k = 0;
    while (!lcd_e && k < 20) begin cyc(); k++; end
    check("holdoff in EPW", lcd_e, 1);
    req1_valid = 1'b1; req1_rs = 1'b0; req1_data = 8'h34;
    bad = 0; k = 0;
    while (busy && k < 100) begin
      #1; if (req1_ready) bad++;
      @(posedge sysclk); #1; k++;
    end
    check("holdoff ready held", bad, 0);
    #1; check("holdoff first idle accept", req1_ready, 1);
    @(posedge sysclk); #1;
    req1_valid = 1'b0;
    wait_idle(200);
    pop_strobe("holdoff 0", 8'h12, 1, 0);
    pop_strobe("holdoff 1", 8'h34, 0, 1);

    // Reset during EPW clears the bus at once and the transfer is abandoned.
    req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5A;
    wait_hs(id, 8);
    req0_valid = 1'b0;
    k = 0;
    while (!lcd_e && k < 20) begin cyc(); k++; end
    check("reset-mid E high before", lcd_e, 1);
    #2; sysreset_n = 1'b0; #1;
    check("reset-mid lcd_e", lcd_e, 0);
    check("reset-mid lcd_d", lcd_d, 0);
    check("reset-mid busy", busy, RST_BUSY_EXP);
    cyc(); cyc();
    sysreset_n = 1'b1;
    cyc(); cyc();
`ifdef LCD_INIT_EN
    wait_idle(1000);
`else
    check("reset-mid no resume", busy, 0);
`endif
    strobe_q.delete();
    run_vec(mk(1, 0, 8'h66, 0, 0, 8'h00, 0, 8'h66, 0, TS+TE+TH+TX), "after reset");

    // Randomized traffic against a rule-level model: winner is the only valid requester,
    // or the one not served last; wait is TC for RS=0 bytes 1..3, else TX.
    model_last = 0;
    for (int t = 0; t < 40; t++) begin
      rv.v0 = 1'($urandom_range(0, 1));
      rv.v1 = 1'($urandom_range(0, 1));
      rv.rs0 = 1'($urandom_range(0, 1));
      rv.rs1 = 1'($urandom_range(0, 1));
      rv.d0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      rv.d1 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if (!rv.v0 && !rv.v1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
          #1; if (req0_ready || req1_ready || busy) quiet = 1'b0;
          @(posedge sysclk); #1;
        end
        check("rand quiet", quiet, 1);
      end else begin
        if (rv.v0 && rv.v1) w = (model_last == 1) ? 0 : 1;
        else w = rv.v1 ? 1 : 0;
        rv.gid = 1'(w);
        rv.ed  = (w == 1) ? rv.d1 : rv.d0;
        rv.ers = (w == 1) ? rv.rs1 : rv.rs0;
        clr = !rv.ers && (rv.ed >= 8'd1) && (rv.ed <= 8'd3);
        rv.ebusy = TS + TE + TH + (clr ? TC : TX);
        model_last = w;
        run_vec(rv, $sformatf("rand%0d", t));
      end
    end

    check("ready overlap", viol_both, 0);
    check("lcd_rw stuck 0", viol_rw, 0);
    check("ready while busy", viol_rdy_busy, 0);
    check("no stray strobes", strobe_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
